time_countdown: RTL and testbench

//   Countdown timer driven by the 4 Hz game tick.
//   - Loads a start value, decrements once per enabled tick and stops at zero.
//   - Flags expiry with a one-cycle done pulse and a level flag.
//   - Sits beside the up-counting game timer and supplies the round time limit
//     to the game controller and display path.

---
 rtl/time_countdown.sv | 101 ++++++++++
 tb/tb_time_countdown.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_countdown.sv
// Round-time countdown on the 4 Hz tick: load, run, pause, expire,
// with optional auto-reload of the last loaded value.
module time_countdown #(
   parameter int WIDTH       = 5,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic             clk_4_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             start_i,
   input  logic             pause_i,
   output logic [WIDTH-1:0] count_o,
   output logic             running_o,
   output logic             expired_o,
   output logic             done_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSED,
      S_EXPIRED
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload;
   logic             r_done;
   logic [WIDTH-1:0] w_dec;
   logic             w_go;

   assign w_dec = r_count - ONE;
   assign w_go  = start_i && !pause_i;

   always_ff @(posedge clk_4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (clear_i) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_reload <= '0;
         end else if (load_i) begin
            r_state  <= S_IDLE;
            r_count  <= load_val_i;
            r_reload <= load_val_i;
         end else begin
            unique case (r_state)
               S_RUN: begin
                  if (pause_i) begin
                     r_state <= S_PAUSED;
                  end else if (r_count != '0) begin
                     r_count <= w_dec;
                     if (w_dec == '0) begin
                        r_state <= S_EXPIRED;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     // count already empty: never wrap below zero
                     r_state <= S_EXPIRED;
                  end
               end
               S_PAUSED: begin
                  if (w_go) r_state <= S_RUN;
               end
               S_EXPIRED: begin
                  r_count <= '0;
                  if (AUTO_RELOAD && r_reload != '0) begin
                     r_count <= r_reload;
                     r_state <= S_RUN;
                  end
               end
               default: begin
                  if (w_go) begin
                     if (r_count == '0) begin
                        r_state <= S_EXPIRED;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_RUN;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign count_o   = r_count;
   assign running_o = (r_state == S_RUN);
   assign expired_o = (r_state == S_EXPIRED);
   assign done_o    = r_done;

endmodule

// File: tb/tb_time_countdown.sv
// Bench for time_countdown: one plain and one auto-reload instance
// driven in parallel, checked against constants and a behavioural model.
module tb_time_countdown;

   localparam int MD_IDLE = 0;
   localparam int MD_RUN  = 1;
   localparam int MD_PAU  = 2;
   localparam int MD_EXP  = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       clr = 1'b0;
   logic       ld = 1'b0;
   logic       st = 1'b0;
   logic       ps = 1'b0;
   logic [4:0] lv = '0;

   logic [4:0] q_cnt [2];
   logic       q_run [2];
   logic       q_exp [2];
   logic       q_dn  [2];

   int m_cnt  [2];
   int m_rel  [2];
   int m_mode [2];
   bit m_done [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   time_countdown #(.WIDTH(5), .AUTO_RELOAD(1'b0)) u_plain (
      .clk_4_i(clk), .rst_ni(rst_n), .clear_i(clr), .load_i(ld),
      .load_val_i(lv), .start_i(st), .pause_i(ps),
      .count_o(q_cnt[0]), .running_o(q_run[0]),
      .expired_o(q_exp[0]), .done_o(q_dn[0])
   );

   time_countdown #(.WIDTH(5), .AUTO_RELOAD(1'b1)) u_auto (
      .clk_4_i(clk), .rst_ni(rst_n), .clear_i(clr), .load_i(ld),
      .load_val_i(lv), .start_i(st), .pause_i(ps),
      .count_o(q_cnt[1]), .running_o(q_run[1]),
      .expired_o(q_exp[1]), .done_o(q_dn[1])
   );

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i]  = 0;
         m_rel[i]  = 0;
         m_mode[i] = MD_IDLE;
         m_done[i] = 1'b0;
      end
   endtask

   // One tick of the round timer as described in words: time left,
   // remembered start value, and what the timer is currently doing.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         if (clr) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_mode[i] = MD_IDLE;
         end else if (ld) begin
            m_cnt[i] = lv; m_rel[i] = lv; m_mode[i] = MD_IDLE;
         end else if (m_mode[i] == MD_RUN) begin
            if (ps) m_mode[i] = MD_PAU;
            else begin
               if (m_cnt[i] > 0) m_cnt[i]--;
               if (m_cnt[i] == 0) begin
                  m_mode[i] = MD_EXP; m_done[i] = 1'b1;
               end
            end
         end else if (m_mode[i] == MD_PAU) begin
            if (st && !ps) m_mode[i] = MD_RUN;
         end else if (m_mode[i] == MD_EXP) begin
            if (i == 1 && m_rel[i] != 0) begin
               m_cnt[i] = m_rel[i]; m_mode[i] = MD_RUN;
            end
         end else if (st && !ps) begin
            if (m_cnt[i] == 0) begin
               m_mode[i] = MD_EXP; m_done[i] = 1'b1;
            end else m_mode[i] = MD_RUN;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if (q_cnt[i] !== 5'd0 || q_run[i] !== 1'b0 ||
             q_exp[i] !== 1'b0 || q_dn[i] !== 1'b0) begin
            n_err++;
            $display("FAIL reset[%0d]: cnt=%0d run=%b exp=%b dn=%b want 0,0,0,0",
                     i, q_cnt[i], q_run[i], q_exp[i], q_dn[i]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_countdown();
      ld = 1'b1; lv = 5'd5;
      tick();
      ld = 1'b0; st = 1'b1;
      tick();
      st = 1'b0;
      n_vec++;
      if (q_cnt[0] !== 5'd5 || q_run[0] !== 1'b1) begin
         n_err++;
         $display("FAIL start: cnt=%0d run=%b want 5,1", q_cnt[0], q_run[0]);
      end
      for (int k = 4; k >= 0; k--) begin
         tick();
         n_vec++;
         if (q_cnt[0] !== 5'(k) || q_dn[0] !== (k == 0) ||
             q_run[0] !== (k != 0) || q_exp[0] !== (k == 0)) begin
            n_err++;
            $display("FAIL countdown k=%0d: cnt=%0d dn=%b run=%b exp=%b",
                     k, q_cnt[0], q_dn[0], q_run[0], q_exp[0]);
         end
      end
      for (int k = 0; k < 10; k++) begin
         st = (k == 3);
         tick();
         n_vec++;
         if (q_cnt[0] !== 5'd0 || q_exp[0] !== 1'b1 || q_dn[0] !== 1'b0) begin
            n_err++;
            $display("FAIL hold0 k=%0d: cnt=%0d exp=%b dn=%b want 0,1,0",
                     k, q_cnt[0], q_exp[0], q_dn[0]);
         end
      end
      st = 1'b0;
   endtask

   task automatic test_pause();
      ld = 1'b1; lv = 5'd9;
      tick();
      ld = 1'b0; st = 1'b1;
      tick();
      st = 1'b0;
      repeat (3) tick();
      ps = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_vec++;
         if (q_cnt[0] !== 5'd6 || q_run[0] !== 1'b0) begin
            n_err++;
            $display("FAIL pause k=%0d: cnt=%0d run=%b want 6,0",
                     k, q_cnt[0], q_run[0]);
         end
      end
      ps = 1'b0; st = 1'b1;
      tick();
      st = 1'b0;
      n_vec++;
      if (q_cnt[0] !== 5'd6 || q_run[0] !== 1'b1) begin
         n_err++;
         $display("FAIL resume: cnt=%0d run=%b want 6,1", q_cnt[0], q_run[0]);
      end
      tick();
      n_vec++;
      if (q_cnt[0] !== 5'd5) begin
         n_err++;
         $display("FAIL resume+1: cnt=%0d want 5", q_cnt[0]);
      end
   endtask

   task automatic test_load_zero();
      ld = 1'b1; lv = 5'd0;
      tick();
      ld = 1'b0; st = 1'b1;
      tick();
      st = 1'b0;
      n_vec++;
      if (q_exp[0] !== 1'b1 || q_dn[0] !== 1'b1 || q_cnt[0] !== 5'd0) begin
         n_err++;
         $display("FAIL zero_start: exp=%b dn=%b cnt=%0d want 1,1,0",
                  q_exp[0], q_dn[0], q_cnt[0]);
      end
      tick();
      st = 1'b1;
      tick();
      st = 1'b0;
      n_vec++;
      if (q_dn[0] !== 1'b0 || q_exp[0] !== 1'b1 || q_dn[1] !== 1'b0) begin
         n_err++;
         $display("FAIL zero_restart: dn=%b exp=%b dn_auto=%b want 0,1,0",
                  q_dn[0], q_exp[0], q_dn[1]);
      end
   endtask

   task automatic test_load_in_run();
      ld = 1'b1; lv = 5'd20;
      tick();
      ld = 1'b0; st = 1'b1;
      tick();
      st = 1'b0;
      repeat (8) tick();
      n_vec++;
      if (q_cnt[0] !== 5'd12) begin
         n_err++;
         $display("FAIL run20: cnt=%0d want 12", q_cnt[0]);
      end
      ld = 1'b1; lv = 5'd7; st = 1'b1;
      tick();
      ld = 1'b0; st = 1'b0;
      n_vec++;
      if (q_cnt[0] !== 5'd7 || q_run[0] !== 1'b0 ||
          q_exp[0] !== 1'b0 || q_dn[0] !== 1'b0) begin
         n_err++;
         $display("FAIL load_run: cnt=%0d run=%b exp=%b dn=%b want 7,0,0,0",
                  q_cnt[0], q_run[0], q_exp[0], q_dn[0]);
      end
   endtask

   task automatic test_auto_reload();
      ld = 1'b1; lv = 5'd2;
      tick();
      ld = 1'b0; st = 1'b1;
      tick();
      st = 1'b0;
      for (int r = 0; r < 3; r++) begin
         for (int k = 1; k >= -1; k--) begin
            tick();
            n_vec++;
            if (q_cnt[1] !== 5'(k < 0 ? 2 : k) || q_dn[1] !== (k == 0) ||
                q_exp[1] !== (k == 0) || q_run[1] !== (k != 0)) begin
               n_err++;
               $display("FAIL reload r=%0d k=%0d: cnt=%0d dn=%b exp=%b run=%b",
                        r, k, q_cnt[1], q_dn[1], q_exp[1], q_run[1]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      ld = 1'b1; lv = 5'd6;
      tick();
      ld = 1'b0; st = 1'b1;
      tick();
      st = 1'b0;
      repeat (2) tick();
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (q_cnt[0] !== 5'd0 || q_run[0] !== 1'b0 || q_dn[0] !== 1'b0 ||
          q_cnt[1] !== 5'd0 || q_run[1] !== 1'b0) begin
         n_err++;
         $display("FAIL async_rst: cnt=%0d/%0d run=%b/%b dn=%b want 0",
                  q_cnt[0], q_cnt[1], q_run[0], q_run[1], q_dn[0]);
      end
      #1 rst_n = 1'b1;
      tick();
      n_vec++;
      if (q_cnt[0] !== 5'd0 || q_run[0] !== 1'b0 || q_dn[0] !== 1'b0) begin
         n_err++;
         $display("FAIL post_rst: cnt=%0d run=%b dn=%b want 0,0,0",
                  q_cnt[0], q_run[0], q_dn[0]);
      end
   endtask

   task automatic test_clear_expired();
      ld = 1'b1; lv = 5'd1;
      tick();
      ld = 1'b0; st = 1'b1;
      tick();
      st = 1'b0;
      tick();
      n_vec++;
      if (q_exp[0] !== 1'b1 || q_dn[0] !== 1'b1) begin
         n_err++;
         $display("FAIL exp1: exp=%b dn=%b want 1,1", q_exp[0], q_dn[0]);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if (q_cnt[i] !== 5'd0 || q_exp[i] !== 1'b0 ||
             q_run[i] !== 1'b0 || q_dn[i] !== 1'b0) begin
            n_err++;
            $display("FAIL clear[%0d]: cnt=%0d exp=%b run=%b dn=%b want 0",
                     i, q_cnt[i], q_exp[i], q_run[i], q_dn[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         clr = ($urandom_range(0, 59) == 0);
         ld  = ($urandom_range(0, 11) == 0);
         lv  = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) lv = 5'($urandom_range(0, 3));
         st  = ($urandom_range(0, 2) == 0);
         ps  = ($urandom_range(0, 6) == 0);
         tick();
         for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (q_cnt[i] !== 5'(m_cnt[i]) ||
                q_run[i] !== (m_mode[i] == MD_RUN) ||
                q_exp[i] !== (m_mode[i] == MD_EXP) ||
                q_dn[i]  !== m_done[i]) begin
               n_err++;
               $display("FAIL random[%0d] n=%0d: cnt=%0d run=%b exp=%b dn=%b want %0d,%b,%b,%b",
                        i, n, q_cnt[i], q_run[i], q_exp[i], q_dn[i], m_cnt[i],
                        m_mode[i] == MD_RUN, m_mode[i] == MD_EXP, m_done[i]);
            end
         end
      end
      clr = 1'b0; ld = 1'b0; st = 1'b0; ps = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_countdown();
      test_pause();
      test_load_zero();
      test_load_in_run();
      test_auto_reload();
      test_async_reset();
      test_clear_expired();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
